// File: rtl/unidade_entrada_pkg.sv
// -----------------------------------------------------------------------------
// unidade_entrada_pkg
// Shared definitions for the input unit: default widths and debounce time,
// the FSM state encoding, and a small helper that decides when the
// "waiting for user" LED is lit.
// -----------------------------------------------------------------------------
package unidade_entrada_pkg;

    localparam int DEF_SW_W            = 11;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;   // 10 ms @ 50 MHz
    localparam int DEF_CNT_W           = 20;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ARMED       = 3'd1,
        ST_DEB_PRESS   = 3'd2,
        ST_CAPTURE     = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } state_t;

    // The user is expected to act only while armed or while a press is
    // being debounced.
    function automatic logic espera(input state_t s);
        return (s == ST_ARMED) || (s == ST_DEB_PRESS);
    endfunction

endpackage

// File: rtl/sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
// Two-flop synchroniser for asynchronous board inputs.
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset; both flops load RESET_VAL
//   d_i      raw asynchronous input (W bits)
//   q_o      synchronised output (W bits), two cycles behind d_i
// -----------------------------------------------------------------------------
module sincronizador #(
    parameter int           W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // The reset value lets the button chain start in the "released" level,
    // so leaving reset never looks like a press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/unidade_entrada.sv
// -----------------------------------------------------------------------------
// unidade_entrada
// Input unit: synchronises the board switches and the Enter key, debounces
// the key, and on an IN instruction stalls the processor until the user
// confirms a value. The captured value is presented zero-extended with a
// one-cycle Pronto strobe for write-back.
//   CLK            system clock, rising edge
//   Reset          asynchronous active-low reset
//   FPGA_Switches  raw switch levels (SW_W bits)
//   Botao          raw Enter key, active-low
//   InRequest      current instruction is IN (held while stalled)
//   Stall          freeze fetch/write-back while waiting for input
//   Pronto         one-cycle strobe, DadoEntrada valid for write-back
//   DadoEntrada    last captured value, {zeros, switches}
//   LED_Espera     lit while waiting for the user
// -----------------------------------------------------------------------------
module unidade_entrada
    import unidade_entrada_pkg::*;
#(
    parameter int SW_W            = DEF_SW_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [SW_W-1:0]   FPGA_Switches,
    input  logic              Botao,
    input  logic              InRequest,
    output logic              Stall,
    output logic              Pronto,
    output logic [DATA_W-1:0] DadoEntrada,
    output logic              LED_Espera
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]   swSync;
    logic              botaoSync;
    logic              btn;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic              pronto_q;
    logic              led_q;

    sincronizador #(
        .W         (1),
        .RESET_VAL (1'b1)
    ) u_sync_botao (
        .clk_i  (CLK),
        .rst_ni (Reset),
        .d_i    (Botao),
        .q_o    (botaoSync)
    );

    sincronizador #(
        .W         (SW_W),
        .RESET_VAL ('0)
    ) u_sync_switches (
        .clk_i  (CLK),
        .rst_ni (Reset),
        .d_i    (FPGA_Switches),
        .q_o    (swSync)
    );

    // Key is active-low on the board; inside the unit 1 means pressed.
    assign btn = ~botaoSync;

    // Next-state logic. A press must stay stable for DEBOUNCE_CYCLES before
    // capture, and after capture the release must also stay stable before
    // going idle, so one long press can never serve two IN instructions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dado_d  = dado_q;
        unique case (state_q)
            ST_IDLE: begin
                if (InRequest) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!InRequest) begin
                    state_d = ST_IDLE;
                end else if (btn) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!btn) begin
                    state_d = ST_ARMED;
                end else if (!InRequest) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_CAPTURE;
                    dado_d  = DATA_W'(swSync);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_DEB_RELEASE;
                cnt_d   = '0;
            end
            ST_DEB_RELEASE: begin
                if (btn) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pronto and the LED are registered from the next state so that they
    // line up exactly with the state they describe and never see the
    // switches combinationally.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dado_q   <= '0;
            pronto_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dado_q   <= dado_d;
            pronto_q <= (state_d == ST_CAPTURE);
            led_q    <= espera(state_d);
        end
    end

    // Combinational so the PC is held in the very cycle IN appears; released
    // only in CAPTURE, which is the write-back cycle. Gated by reset so a
    // held IN level cannot freeze the PC while the unit is being reset.
    assign Stall       = InRequest & Reset & (state_q != ST_CAPTURE);
    assign Pronto      = pronto_q;
    assign DadoEntrada = dado_q;
    assign LED_Espera  = led_q;

endmodule

// File: tb/tb_unidade_entrada.sv
// -----------------------------------------------------------------------------
// tb_unidade_entrada
// Directed bench for the input unit with a short debounce time (4 cycles).
// Inputs change on the falling edge; outputs are looked at on the falling
// edge (or just after an asynchronous change).
// -----------------------------------------------------------------------------
module tb_unidade_entrada;

    localparam int DEB = 4;

    logic        clock = 1'b0;
    logic        resetN;
    logic [10:0] switches;
    logic        botao;
    logic        inReq;
    logic        stall;
    logic        pronto;
    logic [31:0] dado;
    logic        led;

    int checkCount = 0;
    int errorCount = 0;
    int idx;
    int pulses;
    int firstIdx;

    always #5 clock = ~clock;

    unidade_entrada #(
        .SW_W            (11),
        .DATA_W          (32),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .CLK           (clock),
        .Reset         (resetN),
        .FPGA_Switches (switches),
        .Botao         (botao),
        .InRequest     (inReq),
        .Stall         (stall),
        .Pronto        (pronto),
        .DadoEntrada   (dado),
        .LED_Espera    (led)
    );

    // Single point of comparison: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive all functional inputs at once.
    task automatic applyStimulus(input logic [10:0] sw, input logic req, input logic btnRaw);
        switches = sw;
        inReq    = req;
        botao    = btnRaw;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Returns the cycle count at which Pronto was seen, or -1 on timeout.
    task automatic waitPronto(input int maxCycles, output int foundAt);
        foundAt = -1;
        for (int i = 1; i <= maxCycles; i++) begin
            @(negedge clock);
            if (pronto === 1'b1) begin
                foundAt = i;
                break;
            end
        end
    endtask

    // Count Pronto pulses over n cycles.
    task automatic countPronto(input int n, output int count);
        count = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (pronto === 1'b1) count++;
        end
    endtask

    // Let go of the key, drop the request and let the release debounce finish.
    task automatic releaseAndSettle();
        botao = 1'b1;
        inReq = 1'b0;
        waitCycles(12);
    endtask

    initial begin
        // ---------------- reset values ----------------
        resetN = 1'b0;
        applyStimulus(11'h000, 1'b1, 1'b1);
        #12;
        checkOutput("reset_stall_gated", {31'd0, stall}, 32'd0);
        checkOutput("reset_pronto", {31'd0, pronto}, 32'd0);
        checkOutput("reset_led", {31'd0, led}, 32'd0);
        checkOutput("reset_dado", dado, 32'd0);
        applyStimulus(11'h000, 1'b0, 1'b1);
        @(negedge clock);
        resetN = 1'b1;
        waitCycles(2);

        // ---------------- clean press, 5A5 ----------------
        applyStimulus(11'h5A5, 1'b1, 1'b1);
        #1;
        checkOutput("clean_stall_immediate", {31'd0, stall}, 32'd1);
        @(negedge clock);
        checkOutput("clean_led_armed", {31'd0, led}, 32'd1);
        botao = 1'b0;
        countPronto(6, pulses);
        checkOutput("clean_no_early_pronto", pulses, 32'd0);
        checkOutput("clean_stall_debounce", {31'd0, stall}, 32'd1);
        @(negedge clock);
        checkOutput("clean_pronto_at_7", {31'd0, pronto}, 32'd1);
        checkOutput("clean_stall_in_capture", {31'd0, stall}, 32'd0);
        checkOutput("clean_dado", dado, 32'h000005A5);
        inReq = 1'b0;
        @(negedge clock);
        checkOutput("clean_pronto_one_cycle", {31'd0, pronto}, 32'd0);
        releaseAndSettle();
        checkOutput("clean_led_idle", {31'd0, led}, 32'd0);

        // ---------------- bouncy press: 1,0,1 then stable ----------------
        applyStimulus(11'h123, 1'b1, 1'b1);
        waitCycles(1);
        botao    = 1'b0;
        pulses   = 0;
        firstIdx = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (pronto === 1'b1) begin
                pulses++;
                if (firstIdx < 0) firstIdx = i;
                inReq = 1'b0;
            end
            if (i == 2) botao = 1'b1;
            if (i == 4) botao = 1'b0;
        end
        checkOutput("bouncy_first_pronto", firstIdx, 32'd11);
        checkOutput("bouncy_single_pronto", pulses, 32'd1);
        checkOutput("bouncy_dado", dado, 32'h00000123);
        releaseAndSettle();

        // ---------------- held key across two back-to-back IN ----------------
        applyStimulus(11'h0AA, 1'b1, 1'b1);
        waitCycles(1);
        botao = 1'b0;
        waitPronto(20, idx);
        checkOutput("b2b_first_latency", idx, 32'd7);
        checkOutput("b2b_first_dado", dado, 32'h000000AA);
        switches = 11'h7FF;
        countPronto(15, pulses);
        checkOutput("b2b_held_no_pronto", pulses, 32'd0);
        checkOutput("b2b_held_stall", {31'd0, stall}, 32'd1);
        botao = 1'b1;
        countPronto(10, pulses);
        checkOutput("b2b_release_no_pronto", pulses, 32'd0);
        checkOutput("b2b_rearmed_led", {31'd0, led}, 32'd1);
        checkOutput("b2b_rearmed_stall", {31'd0, stall}, 32'd1);
        botao = 1'b0;
        waitPronto(20, idx);
        checkOutput("b2b_second_latency", idx, 32'd7);
        checkOutput("b2b_second_dado", dado, 32'h000007FF);
        releaseAndSettle();

        // ---------------- switch change after capture ----------------
        applyStimulus(11'h001, 1'b1, 1'b1);
        waitCycles(1);
        botao = 1'b0;
        waitPronto(20, idx);
        checkOutput("hold_capture_seen", idx, 32'd7);
        checkOutput("hold_capture", dado, 32'h00000001);
        inReq    = 1'b0;
        switches = 11'h002;
        releaseAndSettle();
        checkOutput("hold_after_change", dado, 32'h00000001);
        applyStimulus(11'h002, 1'b1, 1'b1);
        waitCycles(1);
        botao = 1'b0;
        waitPronto(20, idx);
        checkOutput("hold_next_capture", dado, 32'h00000002);
        releaseAndSettle();

        // ---------------- IN aborted while armed ----------------
        applyStimulus(11'h055, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("abort_led_armed", {31'd0, led}, 32'd1);
        inReq = 1'b0;
        #1;
        checkOutput("abort_stall_drop", {31'd0, stall}, 32'd0);
        @(negedge clock);
        checkOutput("abort_led_off", {31'd0, led}, 32'd0);
        botao = 1'b0;
        countPronto(8, pulses);
        checkOutput("abort_no_pronto", pulses, 32'd0);
        checkOutput("abort_dado_kept", dado, 32'h00000002);
        botao = 1'b1;
        waitCycles(4);

        // ---------------- reset in the middle of a press debounce ----------------
        applyStimulus(11'h3C3, 1'b1, 1'b1);
        waitCycles(1);
        botao = 1'b0;
        waitCycles(4);
        checkOutput("midreset_pre_led", {31'd0, led}, 32'd1);
        resetN = 1'b0;
        #1;
        checkOutput("midreset_stall", {31'd0, stall}, 32'd0);
        checkOutput("midreset_pronto", {31'd0, pronto}, 32'd0);
        checkOutput("midreset_led", {31'd0, led}, 32'd0);
        checkOutput("midreset_dado", dado, 32'd0);
        applyStimulus(11'h3C3, 1'b0, 1'b1);
        @(negedge clock);
        resetN = 1'b1;
        waitCycles(3);
        checkOutput("postreset_led", {31'd0, led}, 32'd0);
        checkOutput("postreset_stall", {31'd0, stall}, 32'd0);
        checkOutput("postreset_dado", dado, 32'd0);
        inReq = 1'b1;
        @(negedge clock);
        checkOutput("postreset_armed", {31'd0, led}, 32'd1);
        countPronto(10, pulses);
        checkOutput("postreset_no_pronto", pulses, 32'd0);
        inReq = 1'b0;
        waitCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
